// File: rtl/serial_tx.sv
// Serial flit transmitter: start bit, LSB-first data, optional even parity, stop bit.
// Each bit is held for CLKS_PER_BIT cycles; tx, busy and done all come straight from flops.
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 4
`endif

module serial_tx #(
    parameter int FLIT_W       = `PAYLOAD_SIZE + `ADDR_SZ,
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY_EN    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLIT_W-1:0] item_in,
    input  logic              ena,
    output logic              busy,
    output logic              tx,
    output logic              done
);

    localparam int IDX_W = (FLIT_W > 1) ? $clog2(FLIT_W) : 1;
    localparam logic [7:0]       CNT_RELOAD = 8'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(FLIT_W - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [FLIT_W-1:0] shreg_q, shreg_d;
    logic              par_q, par_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              bit_end;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        bit_end = (cnt_q == 8'd0);
        if (state_q != IDLE && !bit_end) begin
            cnt_d = cnt_q - 1'b1;
        end
        case (state_q)
            IDLE: begin
                // The flit and its parity are captured here so later item_in changes cannot leak in.
                if (ena) begin
                    state_d = START;
                    cnt_d   = CNT_RELOAD;
                    idx_d   = '0;
                    shreg_d = item_in;
                    par_d   = ^item_in;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    cnt_d   = CNT_RELOAD;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d   = CNT_RELOAD;
                    shreg_d = shreg_q >> 1;
                    if (idx_q == IDX_LAST) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    cnt_d   = CNT_RELOAD;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are derived from the next state so the registered values line up with state_q.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == STOP) && (cnt_d == 8'd0);
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: two instances (8/1/no-parity and 8/4/parity) on a shared clock and reset.
module tb_serial_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] item_a, item_b;
    logic       ena_a, ena_b;
    logic       busy_a, tx_a, done_a;
    logic       busy_b, tx_b, done_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_tx #(.FLIT_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut_a (
        .clk(clk), .reset(reset), .item_in(item_a), .ena(ena_a),
        .busy(busy_a), .tx(tx_a), .done(done_a)
    );

    serial_tx #(.FLIT_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut_b (
        .clk(clk), .reset(reset), .item_in(item_b), .ena(ena_b),
        .busy(busy_b), .tx(tx_b), .done(done_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected line level for frame bit k: start, 8 data bits LSB first, optional even parity, stop.
    function automatic logic frame_bit(input logic [7:0] d, input int k, input int pe);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (pe != 0 && k == 9) return ^d;
        return 1'b1;
    endfunction

    // Called at the negedge of the first frame cycle; returns at the negedge of the done cycle.
    task automatic check_frame(input int sel, input logic [7:0] d, input int cpb, input int pe,
                               input string tag);
        int nb;
        logic t, b, dn;
        nb = 10 + pe;
        for (int k = 0; k < nb; k++) begin
            for (int c = 0; c < cpb; c++) begin
                if (k != 0 || c != 0) @(negedge clk);
                t  = (sel != 0) ? tx_b   : tx_a;
                b  = (sel != 0) ? busy_b : busy_a;
                dn = (sel != 0) ? done_b : done_a;
                check($sformatf("%s_tx_b%0d_c%0d", tag, k, c), 32'(t), 32'(frame_bit(d, k, pe)));
                check($sformatf("%s_busy_b%0d_c%0d", tag, k, c), 32'(b), 32'd1);
                check($sformatf("%s_done_b%0d_c%0d", tag, k, c), 32'(dn),
                      32'((k == nb - 1) && (c == cpb - 1)));
            end
        end
    endtask

    task automatic check_idle_a(input string tag);
        check({tag, "_tx"},   32'(tx_a),   32'd1);
        check({tag, "_busy"}, 32'(busy_a), 32'd0);
        check({tag, "_done"}, 32'(done_a), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset  = 1'b1;
        ena_a  = 1'b1;
        ena_b  = 1'b0;
        item_a = 8'hA5;
        item_b = 8'h00;

        // Reset with ena held: nothing may start.
        repeat (3) @(negedge clk);
        check_idle_a("rst_a");
        check("rst_b_tx",   32'(tx_b),   32'd1);
        check("rst_b_busy", 32'(busy_b), 32'd0);
        check("rst_b_done", 32'(done_b), 32'd0);

        // 0xA5, accepted in the first cycle with reset low.
        reset = 1'b0;
        @(negedge clk);
        ena_a  = 1'b0;
        item_a = 8'h00;
        check_frame(0, 8'hA5, 1, 0, "a5");
        @(negedge clk);
        check_idle_a("a5_after");

        // 0x07 on the 4-cycle, parity-enabled instance: 44 busy cycles, parity bit 1.
        ena_b  = 1'b1;
        item_b = 8'h07;
        @(negedge clk);
        ena_b  = 1'b0;
        item_b = 8'hFF;
        check_frame(1, 8'h07, 4, 1, "b07");
        @(negedge clk);
        check("b07_after_busy", 32'(busy_b), 32'd0);
        check("b07_after_tx",   32'(tx_b),   32'd1);

        // 0xFF with a 0x3C request pulsed during frame cycle 3.
        ena_a  = 1'b1;
        item_a = 8'hFF;
        @(negedge clk);
        ena_a = 1'b0;
        fork
            check_frame(0, 8'hFF, 1, 0, "ff");
            begin
                repeat (2) @(negedge clk);
                ena_a  = 1'b1;
                item_a = 8'h3C;
                @(negedge clk);
                ena_a = 1'b0;
            end
        join
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_idle_a($sformatf("ff_nosecond%0d", i));
        end

        // ena held high, item alternating: back-to-back frames with a single idle gap cycle.
        ena_a  = 1'b1;
        item_a = 8'h01;
        @(negedge clk);
        item_a = 8'h80;
        check_frame(0, 8'h01, 1, 0, "bb1");
        @(negedge clk);
        check_idle_a("bb_gap1");
        @(negedge clk);
        item_a = 8'h01;
        check_frame(0, 8'h80, 1, 0, "bb2");
        @(negedge clk);
        check_idle_a("bb_gap2");
        @(negedge clk);
        item_a = 8'h80;
        check_frame(0, 8'h01, 1, 0, "bb3");
        ena_a = 1'b0;
        @(negedge clk);
        check_idle_a("bb_end");
        @(negedge clk);
        check_idle_a("bb_end2");

        // Reset during data bit 4 of 0x6A aborts the frame, then a clean 0x3C frame follows.
        ena_a  = 1'b1;
        item_a = 8'h6A;
        @(negedge clk);
        ena_a = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_bit4_tx",   32'(tx_a),   32'd0);
        check("abort_bit4_busy", 32'(busy_a), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_idle_a("abort_rst1");
        @(negedge clk);
        check_idle_a("abort_rst2");
        reset  = 1'b0;
        ena_a  = 1'b1;
        item_a = 8'h3C;
        @(negedge clk);
        ena_a = 1'b0;
        check_frame(0, 8'h3C, 1, 0, "post_rst");
        @(negedge clk);
        check_idle_a("post_rst_after");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
